// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: FSM state encodings,
// reset defaults and the wait-counter width.
package ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t BOOT   = 3'd0;
    localparam state_t FETCH  = 3'd1;
    localparam state_t DECODE = 3'd2;
    localparam state_t EXEC   = 3'd3;
    localparam state_t MEM    = 3'd4;
    localparam state_t WB     = 3'd5;
    localparam state_t PCINC  = 3'd6;
    localparam state_t FAULT  = 3'd7;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0100;
    localparam int unsigned DEFAULT_PC_REG   = 6;
    localparam int unsigned DEFAULT_MAX_WAIT = 15;

    // Wide enough for the largest legal MAX_WAIT of 255.
    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_req_timer.sv
// Bus wait-state counter: counts consecutive cycles a request is stalled and
// flags the cycle in which the MAX_WAIT-th stalled cycle completes.
module mem_req_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  stalled;

    assign stalled = req && !ready;
    assign timeout = stalled && (wait_cnt == WAIT_CNT_W'(MAX_WAIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (stalled) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end else begin
            // Acceptance or an idle bus both restart the count.
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer driving a ready-handshaked memory bus.
// Build macro CTRL_SINGLE_STEP_EN adds a step input that gates instruction fetch.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC),
    parameter int unsigned       PC_REG   = DEFAULT_PC_REG,
    parameter int unsigned       MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] pc_val,
    output logic [DATA_W-1:0] instr,
    input  logic [2:0]        dec_dest,
    input  logic              dec_rd,
    input  logic              dec_wr,
    input  logic              dec_use_imm,
    input  logic [DATA_W-1:0] left_val,
    input  logic [DATA_W-1:0] right_val,
    input  logic [DATA_W-1:0] st_val,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              bus_err,
    output logic [2:0]        state
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("control_sequencer: ADDR_W must not exceed DATA_W");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("control_sequencer: MAX_WAIT must be in 1..255");
    end

    localparam logic [2:0] PC_IDX = 3'(PC_REG);

    logic [DATA_W-1:0] load_buf;
    logic              req;
    logic              timeout;
    logic              fetch_go;
    logic              is_jump;

    assign req     = mem_rd || mem_wr;
    assign is_jump = !dec_wr && (dec_dest == PC_IDX);

`ifdef CTRL_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    mem_req_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bus_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            load_buf  <= '0;
        end else begin
            case (state)
                BOOT: state <= FETCH;

                FETCH: begin
                    // First FETCH cycle issues; pc_val is already current here.
                    if (mem_rd) begin
                        if (mem_ready) begin
                            instr  <= mem_rdata;
                            mem_rd <= 1'b0;
                            state  <= DECODE;
                        end else if (timeout) begin
                            mem_rd  <= 1'b0;
                            bus_err <= 1'b1;
                            state   <= FAULT;
                        end
                    end else if (fetch_go) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_val[ADDR_W-1:0];
                    end
                end

                DECODE: begin
                    alu_a     <= left_val;
                    alu_b     <= dec_use_imm ? imm : right_val;
                    mem_wdata <= st_val;
                    state     <= EXEC;
                end

                EXEC: begin
                    // Request is raised on entry to MEM so a zero-wait access
                    // completes in a single MEM cycle.
                    if (dec_rd || dec_wr) begin
                        mem_addr <= alu_result[ADDR_W-1:0];
                        mem_rd   <= dec_rd;
                        mem_wr   <= dec_wr && !dec_rd;
                        state    <= MEM;
                    end else begin
                        state <= WB;
                    end
                end

                MEM: begin
                    if (req && mem_ready) begin
                        if (mem_rd) begin
                            load_buf <= mem_rdata;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= WB;
                    end else if (timeout) begin
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= FAULT;
                    end
                end

                WB:      state <= is_jump ? FETCH : PCINC;
                PCINC:   state <= FETCH;
                FAULT:   state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

    // Register-file port is decoded from state so each write is exactly one
    // state-cycle long and sees live pc_val/alu_result.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state)
            BOOT: begin
                rf_we    = 1'b1;
                rf_waddr = PC_IDX;
                rf_wdata = RESET_PC;
            end
            WB: begin
                if (!dec_wr) begin
                    rf_we    = 1'b1;
                    rf_waddr = dec_dest;
                    rf_wdata = dec_rd ? load_buf : alu_result;
                end
            end
            PCINC: begin
                rf_we    = 1'b1;
                rf_waddr = PC_IDX;
                rf_wdata = pc_val + DATA_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction vector table with a
// bus responder, an adder ALU and scoreboard queues for rf writes and bus accepts.
`timescale 1ns/1ps
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ready;
    logic [15:0] pc_val, instr;
    logic [2:0]  dec_dest;
    logic        dec_rd, dec_wr, dec_use_imm;
    logic [15:0] left_val, right_val, st_val, imm;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        bus_err;
    logic [2:0]  state;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CTRL_SINGLE_STEP_EN
        .step        (step),
`endif
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_ready   (mem_ready),
        .pc_val      (pc_val),
        .instr       (instr),
        .dec_dest    (dec_dest),
        .dec_rd      (dec_rd),
        .dec_wr      (dec_wr),
        .dec_use_imm (dec_use_imm),
        .left_val    (left_val),
        .right_val   (right_val),
        .st_val      (st_val),
        .imm         (imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .bus_err     (bus_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Environment ALU: plain adder.
    assign alu_result = alu_a + alu_b;

    typedef struct { logic [15:0] data; int waits; } resp_t;
    typedef struct { logic is_wr; logic [15:0] addr; logic [15:0] wdata; } bus_t;
    typedef struct { logic [2:0] waddr; logic [15:0] wdata; } rfw_t;
    typedef struct {
        logic [15:0] pc, word;
        logic [2:0]  dest;
        logic        rd, wr, use_imm;
        logic [15:0] left, right, st, immv, ldata;
        int          fwait, mwait;
        logic        spurious;
        logic [15:0] exp_res;
        int          exp_cycles;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    resp_t resp_q[$];
    bus_t  bus_q[$];
    rfw_t  rf_q[$];
    logic  mon_en   = 1'b0;
    logic  spurious = 1'b0;
    vec_t  vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: each request uses the head response entry, raising
    // mem_ready after its wait count; an empty queue never responds.
    initial begin
        int   waited;
        logic granted;
        waited    = 0;
        granted   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (granted) begin
                if (resp_q.size() > 0) resp_q.delete(0);
                granted = 1'b0;
                waited  = 0;
            end
            mem_ready = 1'b0;
            if (rst) begin
                waited = 0;
            end else if (mem_rd || mem_wr) begin
                if (resp_q.size() > 0 && waited == resp_q[0].waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_q[0].data;
                    granted   = 1'b1;
                end else begin
                    waited++;
                end
            end else begin
                waited    = 0;
                mem_ready = spurious;
            end
        end
    end

    // Monitor: pops scoreboard entries on rf writes and bus acceptances.
    initial begin
        rfw_t e;
        bus_t b;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                if (mem_rd && mem_wr) check("rd_wr_exclusive", 32'({mem_rd, mem_wr}), 32'(0));
                if (rf_we) begin
                    if (rf_q.size() == 0) begin
                        check("rf_unexpected_we", 32'(rf_we), 32'(0));
                    end else begin
                        e = rf_q.pop_front();
                        check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                        check("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
                    end
                end
                if (mem_ready && (mem_rd || mem_wr)) begin
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", 32'(mem_ready), 32'(0));
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_kind", 32'({mem_rd, mem_wr}), b.is_wr ? 32'(1) : 32'(2));
                        check("bus_addr", 32'(mem_addr), 32'(b.addr));
                        if (b.is_wr) check("bus_wdata", 32'(mem_wdata), 32'(b.wdata));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_issue(output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!(state == FETCH && !mem_rd)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_instr(input vec_t v, input int idx);
        logic ok;
        int   cycles, hold;
        wait_issue(ok);
        check($sformatf("v%0d_issue", idx), 32'(ok), 32'(1));
        pc_val      = v.pc;
        dec_dest    = v.dest;
        dec_rd      = v.rd;
        dec_wr      = v.wr;
        dec_use_imm = v.use_imm;
        left_val    = v.left;
        right_val   = v.right;
        st_val      = v.st;
        imm         = v.immv;
        spurious    = v.spurious;
        resp_q.push_back('{v.word, v.fwait});
        bus_q.push_back('{1'b0, v.pc, 16'h0000});
        if (v.rd || v.wr) begin
            resp_q.push_back('{v.ldata, v.mwait});
            bus_q.push_back('{v.wr, v.exp_res, v.st});
        end
        if (!v.wr) rf_q.push_back('{v.dest, v.rd ? v.ldata : v.exp_res});
        if (v.wr || v.dest != 3'd6) rf_q.push_back('{3'd6, v.pc + 16'd1});
        cycles = 0;
        hold   = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (state == MEM && (mem_rd || mem_wr)) hold++;
            if (state == DECODE) check($sformatf("v%0d_instr", idx), 32'(instr), 32'(v.word));
        end while (!(state == FETCH && !mem_rd) && cycles < 100);
        check($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(v.exp_cycles));
        if (v.rd || v.wr) check($sformatf("v%0d_mem_hold", idx), 32'(hold), 32'(v.mwait + 1));
        spurious = 1'b0;
    endtask

    initial begin
        logic ok;
        int   cycles, hold;
        // pc, word, dest, rd, wr, imm?, left, right, st, imm, ldata, fwait, mwait, spur, result, cycles
        vecs[0] = '{16'h0100, 16'h1111, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h9999, 16'h0000, 16'h0005, 16'h0000, 0, 0, 1'b0, 16'h0015, 6};
        vecs[1] = '{16'h0101, 16'h2222, 3'd2, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0234, 16'h0000, 16'h7777, 16'h0000, 2, 0, 1'b0, 16'h1234, 8};
        vecs[2] = '{16'h0102, 16'h3333, 3'd3, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0000, 16'h0004, 16'hBEEF, 0, 3, 1'b0, 16'h0204, 10};
        vecs[3] = '{16'h0103, 16'h4444, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 0, 0, 1'b0, 16'h0301, 7};
        vecs[4] = '{16'h0104, 16'h5555, 3'd6, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 0, 0, 1'b0, 16'h0400, 5};
        vecs[5] = '{16'hFFFF, 16'h6666, 3'd7, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 16'h0001, 6};
        vecs[6] = '{16'h0000, 16'h7777, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 16'h5A5A, 0, 0, 1'b0, 16'h0030, 7};
        vecs[7] = '{16'h0001, 16'h8888, 3'd4, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1, 0, 1'b1, 16'h0142, 7};
        vecs[8] = '{16'h0002, 16'h9999, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0500, 16'h0005, 16'hCAFE, 16'h0000, 16'h0000, 0, 2, 1'b0, 16'h0505, 9};

        rst = 1'b1; pc_val = '0; dec_dest = '0; dec_rd = 1'b0; dec_wr = 1'b0; dec_use_imm = 1'b0;
        left_val = '0; right_val = '0; st_val = '0; imm = '0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'(BOOT));
        check("rst_rf_we", 32'(rf_we), 32'(1));
        check("rst_rf_waddr", 32'(rf_waddr), 32'(6));
        check("rst_rf_wdata", 32'(rf_wdata), 32'(16'h0100));
        check("rst_req", 32'({mem_rd, mem_wr}), 32'(0));
        check("rst_bus_err", 32'(bus_err), 32'(0));
        check("rst_regs", 32'({instr, alu_a}), 32'(0));
        check("rst_regs2", 32'({alu_b, mem_addr}), 32'(0));
        check("rst_wdata", 32'(mem_wdata), 32'(0));
        rf_q.push_back('{3'd6, 16'h0100});
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) run_instr(vecs[i], i);

        // Fetch that is never answered must fault after 15 stalled cycles.
        wait_issue(ok);
        check("to_issue", 32'(ok), 32'(1));
        pc_val = 16'h0020;
        cycles = 0;
        hold   = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (mem_rd) hold++;
        end while (state != FAULT && cycles < 100);
        check("to_stall_cycles", 32'(hold), 32'(15));
        check("to_state", 32'(state), 32'(FAULT));
        check("to_mem_rd", 32'(mem_rd), 32'(0));
        check("to_bus_err", 32'(bus_err), 32'(1));
        repeat (5) @(negedge clk);
        check("to_sticky_state", 32'(state), 32'(FAULT));
        check("to_sticky_err", 32'({bus_err, mem_rd}), 32'(2));

        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("fault_clear_state", 32'(state), 32'(BOOT));
        check("fault_clear_err", 32'(bus_err), 32'(0));
        rf_q.push_back('{3'd6, 16'h0100});
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset while a store is waiting drops the write on that edge.
        wait_issue(ok);
        check("mid_issue", 32'(ok), 32'(1));
        pc_val = 16'h0030; dec_rd = 1'b0; dec_wr = 1'b1; dec_use_imm = 1'b1;
        left_val = 16'h0600; imm = 16'h0000; st_val = 16'hDEAD;
        resp_q.push_back('{16'hAAAA, 0});
        bus_q.push_back('{1'b0, 16'h0030, 16'h0000});
        resp_q.push_back('{16'h0000, 50});
        cycles = 0;
        while (!mem_wr && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check("mid_store_req", 32'(mem_wr), 32'(1));
        mon_en = 1'b0;
        rst    = 1'b1;
        resp_q.delete();
        @(negedge clk);
        check("mid_rst_req", 32'({mem_rd, mem_wr}), 32'(0));
        check("mid_rst_state", 32'(state), 32'(BOOT));
        rf_q.push_back('{3'd6, 16'h0100});
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_write", 32'(mem_wr), 32'(0));
        check("rf_q_drained", 32'(rf_q.size()), 32'(0));
        check("bus_q_drained", 32'(bus_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer; next-generation replacement for the fixed 5-state CPU controller.
- Drives memory through a ready-handshaked bus with wait states and timeout.
- Performs PC auto-increment and a correct store-data path.
- Exposes the register-file, decoder and ALU interfaces as ports; the parent wires those instances.

Parameters:
- DATA_W, 16, data/register width.
- ADDR_W, 16, memory address width; must be <= DATA_W.
- RESET_PC, 16'h0100, PC value written on reset.
- PC_REG, 6, register-file index of PC.
- MAX_WAIT, 15, max cycles to wait for mem_ready before fault; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load/fetch data
- mem_rd  out  1  read request, held until accepted
- mem_wr  out  1  write request, held until accepted
- mem_ready  in  1  request completes in this cycle; mem_rdata valid
- pc_val  in  DATA_W  current PC from register file
- instr  out  DATA_W  instruction register, to decoder
- dec_dest  in  3  destination register index
- dec_rd  in  1  instruction is a load
- dec_wr  in  1  instruction is a store
- dec_use_imm  in  1  operand B = immediate
- left_val  in  DATA_W  register operand A
- right_val  in  DATA_W  register operand B
- st_val  in  DATA_W  store source register value
- imm  in  DATA_W  decoded immediate
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_result  in  DATA_W  ALU result
- rf_we  out  1  register write enable
- rf_waddr  out  3  register write index
- rf_wdata  out  DATA_W  register write data
- bus_err  out  1  sticky memory-timeout flag
- state  out  3  current state, for debug

Behaviour:
- Reset, taking effect on the next clk edge:
  - state=BOOT; rf_we=1, rf_waddr=PC_REG, rf_wdata=RESET_PC.
  - mem_rd=0, mem_wr=0, bus_err=0; instr, alu_a, alu_b, mem_addr, mem_wdata = 0; wait counter = 0.
  - rst asserted mid-transaction drops requests the same edge; no write completes after that edge.
- States and transitions:
  - BOOT: rf_we<=0 -> FETCH.
  - FETCH:
    - Assert mem_rd with mem_addr=pc_val[ADDR_W-1:0].
    - On the cycle mem_ready=1 (mem_rd already high): instr<=mem_rdata, mem_rd<=0 -> DECODE.
  - DECODE: alu_a<=left_val; alu_b<=dec_use_imm ? imm : right_val; mem_wdata<=st_val -> EXEC.
  - EXEC: ALU combinational; one settle cycle.
    - If dec_rd or dec_wr -> MEM; else -> WB.
  - MEM:
    - mem_addr<=alu_result[ADDR_W-1:0]; assert mem_rd=dec_rd or mem_wr=dec_wr.
    - Hold the request until mem_ready; on load, capture mem_rdata into a load buffer.
    - Then -> WB.
  - WB:
    - Stores skip the register write and go to PCINC.
    - Otherwise rf_we=1, rf_waddr=dec_dest, rf_wdata = load ? buffer : alu_result.
    - If dec_dest==PC_REG (jump), skip increment -> FETCH; else -> PCINC.
  - PCINC: rf_we=1, rf_waddr=PC_REG, rf_wdata=pc_val+1 (wraps mod 2^DATA_W) -> FETCH.
  - FAULT:
    - Entered from FETCH or MEM when MAX_WAIT consecutive cycles pass with a request high and no mem_ready.
    - Requests deasserted, bus_err=1; remains until rst.
- Timing and handshake rules:
  - rf_we is a single-cycle pulse; deasserted in all other states.
  - Wait counter clears on every request acceptance.
  - mem_ready high when no request is pending is ignored.
  - mem_rd and mem_wr are never high together.
  - Zero-wait instruction latency: ALU op 6 cycles (FETCH, DECODE, EXEC, WB, PCINC + FETCH accept); load/store 7 cycles.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - The sequencer waits in FETCH, with no mem_rd asserted, until step=1; each step pulse executes exactly one instruction.
  - step held high runs continuously.
- Undefined: no step port; FETCH issues immediately.

Decomposition:
- Package ctrl_pkg holds:
  - State enum localparams: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCINC=6, FAULT=7.
  - Default RESET_PC and PC_REG constants.
- One natural sub-module: mem_req_timer (wait counter plus timeout compare), shared by FETCH and MEM.

Test Plan:
- Reset: rst 2 cycles -> one rf_we pulse, rf_waddr=6, rf_wdata=0x0100; first fetch mem_addr=0x0100.
- ALU op, zero wait: with pc_val=0x0100, ADD imm -> rf write of alu_result to dec_dest; next cycle rf_wdata=0x0101 to reg 6; 6 cycles total.
- Load with 3 wait states: mem_rd held exactly 4 cycles, address=alu_result; mem_rdata=0xBEEF on the ready cycle -> rf_wdata=0xBEEF.
- Store: st_val=0x1234 -> mem_wr with mem_wdata=0x1234; no rf write except the PC increment.
- Timeout: mem_ready never asserted in FETCH -> after 15 cycles bus_err=1, state=7, mem_rd=0; stays until rst.
- Jump and wrap: dec_dest=6 -> no PCINC; pc_val=0xFFFF with non-jump -> PC written 0x0000.
